// File: rtl/regfile_np_pkg.sv
// regfile_np_pkg: shared definitions for the parametrised register file.
// Holds the clear-FSM state encoding and the default geometry constants.
package regfile_np_pkg;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_DEPTH = 8;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/regfile_np_if.sv
// regfile_np_if: bus between decoder/function unit (master) and the register file (slave).
//   AA, BA   read addresses for ports A and B
//   DA, DD   write address and data, RW write enable
//   CLR      bulk-clear request
//   AD, BD   registered read data, BUSY high during a bulk clear
interface regfile_np_if
   import regfile_np_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);
   localparam int AW = $clog2(DEPTH);

   logic [AW-1:0]    AA;
   logic [AW-1:0]    BA;
   logic [AW-1:0]    DA;
   logic [WIDTH-1:0] DD;
   logic             RW;
   logic             CLR;
   logic [WIDTH-1:0] AD;
   logic [WIDTH-1:0] BD;
   logic             BUSY;

   modport master (
      output AA, BA, DA, DD, RW, CLR,
      input  AD, BD, BUSY
   );

   modport slave (
      input  AA, BA, DA, DD, RW, CLR,
      output AD, BD, BUSY
   );

endinterface

// File: rtl/regfile_np_rdport.sv
// regfile_np_rdport: one registered read port of the register file.
//   clk_i, rst_n_i   clock and async active-low reset
//   addr_i           read address, sampled on the edge
//   byp_en_i         a write is really committed this edge (already excludes dropped writes)
//   byp_addr_i/data  write address/data used for write-through bypass
//   mem_i            current array contents
//   clr_i            force the read data to zero (bulk clear in progress)
//   rdata_o          registered read data
module regfile_np_rdport
   import regfile_np_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter bit ZERO_R0 = 1'b0
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic [$clog2(DEPTH)-1:0] addr_i,
   input  logic                     byp_en_i,
   input  logic [$clog2(DEPTH)-1:0] byp_addr_i,
   input  logic [WIDTH-1:0]         byp_data_i,
   input  logic [WIDTH-1:0]         mem_i [DEPTH],
   input  logic                     clr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] rdata_d;
   logic [WIDTH-1:0] rdata_q;

   always_comb begin
      rdata_d = mem_i[addr_i];
      if (clr_i) begin
         rdata_d = '0;
      end else if (byp_en_i && (byp_addr_i == addr_i)) begin
         rdata_d = byp_data_i;
      end else if (ZERO_R0 && (addr_i == '0)) begin
         rdata_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/regfile_np.sv
// regfile_np: parametrised 2-read/1-write register file with optional zero R0,
// write-through bypass and a sequenced bulk clear.
//   CLK      single clock, rising edge
//   RESET_N  asynchronous active-low reset
//   rf       slave side of regfile_np_if (addresses, write data, CLR, AD/BD, BUSY)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | normal reads/writes, CLR starts a clear
// ST_CLEAR | one register zeroed per edge, RW/CLR ignored, AD/BD = 0
module regfile_np
   import regfile_np_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter bit ZERO_R0 = 1'b0
) (
   input logic         CLK,
   input logic         RESET_N,
   regfile_np_if.slave rf
);

   localparam int AW = $clog2(DEPTH);

   state_e           state_q;
   logic [AW-1:0]    cnt_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             wr_en;
   logic             busy;

   // CLR has priority over RW; a dropped write must also suppress the bypass.
   assign wr_en = (state_q == ST_IDLE) && !rf.CLR && rf.RW &&
                  !(ZERO_R0 && (rf.DA == '0));

   assign busy    = (state_q == ST_CLEAR);
   assign rf.BUSY = busy;

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (rf.CLR) begin
                  state_q <= ST_CLEAR;
                  cnt_q   <= '0;
               end else if (wr_en) begin
                  mem_q[rf.DA] <= rf.DD;
               end
            end
            ST_CLEAR: begin
               mem_q[cnt_q] <= '0;
               cnt_q        <= cnt_q + 1'b1;
               if (cnt_q == AW'(DEPTH - 1)) begin
                  state_q <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   regfile_np_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_a (
      .clk_i      (CLK),
      .rst_n_i    (RESET_N),
      .addr_i     (rf.AA),
      .byp_en_i   (wr_en),
      .byp_addr_i (rf.DA),
      .byp_data_i (rf.DD),
      .mem_i      (mem_q),
      .clr_i      (busy),
      .rdata_o    (rf.AD)
   );

   regfile_np_rdport #(
      .WIDTH   (WIDTH),
      .DEPTH   (DEPTH),
      .ZERO_R0 (ZERO_R0)
   ) u_rd_b (
      .clk_i      (CLK),
      .rst_n_i    (RESET_N),
      .addr_i     (rf.BA),
      .byp_en_i   (wr_en),
      .byp_addr_i (rf.DA),
      .byp_data_i (rf.DD),
      .mem_i      (mem_q),
      .clr_i      (busy),
      .rdata_o    (rf.BD)
   );

endmodule

// File: tb/tb_regfile_np.sv
module tb_regfile_np;

   logic CLK;
   logic RESET_N;

   int vectors;
   int miscompares;

   logic [15:0] exp_mem [8];

   regfile_np_if #(.WIDTH(16), .DEPTH(8)) if0 ();
   regfile_np_if #(.WIDTH(16), .DEPTH(8)) if1 ();

   regfile_np #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b0)) dut0 (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .rf      (if0.slave)
   );

   regfile_np #(.WIDTH(16), .DEPTH(8), .ZERO_R0(1'b1)) dut1 (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .rf      (if1.slave)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_inputs();
      if0.AA = '0; if0.BA = '0; if0.DA = '0; if0.DD = '0; if0.RW = 1'b0; if0.CLR = 1'b0;
      if1.AA = '0; if1.BA = '0; if1.DA = '0; if1.DD = '0; if1.RW = 1'b0; if1.CLR = 1'b0;
   endtask

   task automatic wr0(input logic [2:0] a, input logic [15:0] d);
      if0.RW = 1'b1; if0.DA = a; if0.DD = d; if0.CLR = 1'b0;
      tick();
      if0.RW = 1'b0;
      exp_mem[a] = d;
   endtask

   task automatic test_reset();
      RESET_N = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if0.AA = 3'($urandom); if0.BA = 3'($urandom); if0.DA = 3'($urandom);
         if0.DD = 16'($urandom); if0.RW = 1'($urandom); if0.CLR = 1'($urandom);
         tick();
      end
      vectors++;
      if (if0.AD !== 16'h0) begin miscompares++; $display("FAIL reset_ad actual=%h required=0000", if0.AD); end
      vectors++;
      if (if0.BD !== 16'h0) begin miscompares++; $display("FAIL reset_bd actual=%h required=0000", if0.BD); end
      vectors++;
      if (if0.BUSY !== 1'b0) begin miscompares++; $display("FAIL reset_busy actual=%b required=0", if0.BUSY); end
      idle_inputs();
      @(negedge CLK);
      RESET_N = 1'b1;
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0;
      for (int a = 0; a < 8; a++) begin
         if0.AA = 3'(a); if0.BA = 3'(7 - a);
         tick();
         vectors++;
         if (if0.AD !== 16'h0 || if0.BD !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_read[%0d] actual AD=%h BD=%h required 0000/0000", a, if0.AD, if0.BD);
         end
      end
   endtask

   task automatic test_write_read();
      if0.AA = 3'd2; if0.BA = 3'd0;
      wr0(3'd3, 16'hA5A5);
      if0.AA = 3'd3; if0.BA = 3'd3;
      tick();
      vectors++;
      if (if0.AD !== 16'hA5A5) begin miscompares++; $display("FAIL wr_rd_ad actual=%h required=a5a5", if0.AD); end
      vectors++;
      if (if0.BD !== 16'hA5A5) begin miscompares++; $display("FAIL wr_rd_bd actual=%h required=a5a5", if0.BD); end
      if0.AA = 3'd2;
      tick();
      vectors++;
      if (if0.AD !== 16'h0) begin miscompares++; $display("FAIL wr_rd_r2 actual=%h required=0000", if0.AD); end
   endtask

   task automatic test_bypass();
      wr0(3'd4, 16'h0F0F);
      if0.RW = 1'b1; if0.DA = 3'd5; if0.DD = 16'h1234; if0.AA = 3'd5; if0.BA = 3'd4;
      tick();
      exp_mem[5] = 16'h1234;
      vectors++;
      if (if0.AD !== 16'h1234) begin miscompares++; $display("FAIL bypass_ad actual=%h required=1234", if0.AD); end
      vectors++;
      if (if0.BD !== 16'h0F0F) begin miscompares++; $display("FAIL bypass_bd actual=%h required=0f0f", if0.BD); end
      if0.DA = 3'd6; if0.DD = 16'hBEEF; if0.AA = 3'd6; if0.BA = 3'd6;
      tick();
      exp_mem[6] = 16'hBEEF;
      if0.RW = 1'b0;
      vectors++;
      if (if0.AD !== 16'hBEEF || if0.BD !== 16'hBEEF) begin
         miscompares++;
         $display("FAIL bypass_same_addr actual AD=%h BD=%h required beef/beef", if0.AD, if0.BD);
      end
      if0.AA = 3'd5;
      tick();
      vectors++;
      if (if0.AD !== 16'h1234) begin miscompares++; $display("FAIL bypass_commit actual=%h required=1234", if0.AD); end
   endtask

   task automatic test_zero_r0();
      if1.RW = 1'b1; if1.DA = 3'd0; if1.DD = 16'hFFFF; if1.AA = 3'd0; if1.BA = 3'd0;
      tick();
      vectors++;
      if (if1.AD !== 16'h0 || if1.BD !== 16'h0) begin
         miscompares++;
         $display("FAIL zero_r0_same actual AD=%h BD=%h required 0000/0000", if1.AD, if1.BD);
      end
      if1.RW = 1'b0;
      tick();
      vectors++;
      if (if1.AD !== 16'h0) begin miscompares++; $display("FAIL zero_r0_next actual=%h required=0000", if1.AD); end
      if1.RW = 1'b1; if1.DA = 3'd1; if1.DD = 16'h00FF; if1.AA = 3'd1;
      tick();
      if1.RW = 1'b0;
      vectors++;
      if (if1.AD !== 16'h00FF) begin miscompares++; $display("FAIL zero_r0_r1 actual=%h required=00ff", if1.AD); end
      wr0(3'd0, 16'hFFFF);
      if0.AA = 3'd0;
      tick();
      vectors++;
      if (if0.AD !== 16'hFFFF) begin miscompares++; $display("FAIL r0_writable actual=%h required=ffff", if0.AD); end
   endtask

   task automatic test_bulk_clear();
      int busy_cnt;
      int zero_bad;
      int guard;
      for (int i = 0; i < 8; i++) wr0(3'(i), 16'(i + 1));
      if0.CLR = 1'b1; if0.RW = 1'b1; if0.DA = 3'd2; if0.DD = 16'h9999; if0.AA = 3'd2; if0.BA = 3'd1;
      tick();
      if0.CLR = 1'b0;
      vectors++;
      if (if0.BUSY !== 1'b1) begin miscompares++; $display("FAIL clr_busy_rise actual=%b required=1", if0.BUSY); end
      vectors++;
      if (if0.AD !== 16'h0003 || if0.BD !== 16'h0002) begin
         miscompares++;
         $display("FAIL clr_first_read actual AD=%h BD=%h required 0003/0002", if0.AD, if0.BD);
      end
      busy_cnt = (if0.BUSY === 1'b1) ? 1 : 0;
      zero_bad = 0;
      guard = 0;
      // writes during the clear must be ignored
      if0.RW = 1'b1; if0.DA = 3'd5; if0.DD = 16'h7777; if0.AA = 3'd3; if0.BA = 3'd6;
      while (if0.BUSY === 1'b1 && guard < 20) begin
         tick();
         guard++;
         if (if0.BUSY === 1'b1) begin
            busy_cnt++;
            if (if0.AD !== 16'h0 || if0.BD !== 16'h0) zero_bad++;
         end
      end
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0;
      vectors++;
      if (busy_cnt != 8) begin miscompares++; $display("FAIL clr_busy_len actual=%0d required=8", busy_cnt); end
      vectors++;
      if (zero_bad != 0) begin miscompares++; $display("FAIL clr_ad_bd_zero actual=%0d nonzero required=0", zero_bad); end
      vectors++;
      if (if0.AD !== 16'h0) begin miscompares++; $display("FAIL clr_last_read actual=%h required=0000", if0.AD); end
      wr0(3'd4, 16'hCAFE);
      for (int a = 0; a < 8; a++) begin
         if0.AA = 3'(a); if0.BA = 3'(a);
         tick();
         vectors++;
         if (if0.AD !== exp_mem[a] || if0.BD !== exp_mem[a]) begin
            miscompares++;
            $display("FAIL clr_read[%0d] actual AD=%h BD=%h required %h", a, if0.AD, if0.BD, exp_mem[a]);
         end
      end
   endtask

   task automatic test_reset_mid_clear();
      wr0(3'd1, 16'h1111);
      wr0(3'd6, 16'h6666);
      if0.CLR = 1'b1;
      tick();
      if0.CLR = 1'b0;
      tick();
      tick();
      #2;
      RESET_N = 1'b0;
      #1;
      vectors++;
      if (if0.BUSY !== 1'b0) begin miscompares++; $display("FAIL midclr_busy actual=%b required=0", if0.BUSY); end
      for (int i = 0; i < 8; i++) exp_mem[i] = 16'h0;
      @(negedge CLK);
      RESET_N = 1'b1;
      if0.RW = 1'b1; if0.DA = 3'd6; if0.DD = 16'hABCD;
      tick();
      if0.RW = 1'b0;
      exp_mem[6] = 16'hABCD;
      for (int a = 0; a < 8; a++) begin
         if0.AA = 3'(a); if0.BA = 3'(7 - a);
         tick();
         vectors++;
         if (if0.AD !== exp_mem[a] || if0.BD !== exp_mem[7 - a]) begin
            miscompares++;
            $display("FAIL midclr_read[%0d] actual AD=%h BD=%h required %h/%h",
                     a, if0.AD, if0.BD, exp_mem[a], exp_mem[7 - a]);
         end
      end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      RESET_N = 1'b0;
      idle_inputs();
      test_reset();
      test_write_read();
      test_bypass();
      test_zero_r0();
      test_bulk_clear();
      test_reset_mid_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
